spi_slave_tx: RTL
=================

Name: spi_slave_tx

Overview:
- SPI responder-side transmitter: returns bytes to the SPI master on MISO while the master clocks a frame with cs/sclk.
- Runs entirely on the system clock; cs, sclk and mosi are oversampled through synchronizers.
- Mode 0 (CPOL=0, CPHA=0), LSB first, 8-bit frames, matching the existing master/slave pair.
- Byte source is a one-entry holding register with a valid/ready handshake, so consecutive bytes go out back-to-back.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for cs and sclk; mosi is delayed to match.
- IDLE_BYTE, 8'hFF, byte shifted out when no data is held at load time (underrun).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active high.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding register empty; write accepted when tx_valid && tx_ready.
- cs  input  1  chip select from master, active low.
- sclk  input  1  serial clock from master.
- mosi  input  1  master data (used only with the optional feature).
- miso  output  1  serial data to master.
- miso_oe  output  1  MISO output enable; high only while selected.
- tx_done  output  1  one-cycle pulse when 8 bits of a byte have been sampled by the master.
- underrun  output  1  one-cycle pulse when IDLE_BYTE is loaded.
- aborted  output  1  one-cycle pulse when cs deasserts mid-byte.

Behaviour:
- Reset (asynchronous, takes effect without a clk edge):
  - miso=0, miso_oe=0, tx_ready=1, tx_done=0, underrun=0, aborted=0.
  - bit_cnt=0, hold empty, state IDLE.
  - Synchronizer flops reset to cs=1, sclk=0.
- Edge detect: compare the synchronized value with its previous value to form cs_fall, cs_rise, sclk_rise and sclk_fall, each one cycle wide.
- Master sclk half-period must be at least SYNC_STAGES+2 clk cycles; the team's master uses 11, so this holds.
- State IDLE:
  - miso_oe=0.
  - On cs_fall, go to SHIFT and load the shift register.
- Load rule:
  - If hold is full: shreg <= hold, hold becomes empty, tx_ready rises the next cycle.
  - Otherwise: shreg <= IDLE_BYTE and pulse underrun.
  - miso_oe=1 and miso=shreg[0] from the cycle after load.
- Latency: cs falling at the pin to valid miso is SYNC_STAGES+1 clk.
- State SHIFT, sclk_rise:
  - The master samples on this edge; bit_cnt increments.
  - When bit_cnt reaches 8: pulse tx_done, set bit_cnt=0, set the reload flag.
- State SHIFT, sclk_fall:
  - If reload is pending: perform the load rule (back-to-back byte) and clear the flag.
  - Otherwise: shreg >>= 1 and miso=shreg[0].
- State SHIFT, cs_rise:
  - Go to IDLE, miso_oe=0, bit_cnt=0, clear reload.
  - If bit_cnt != 0, pulse aborted. The partial byte is discarded.
  - Hold register is untouched.
- Simultaneous events:
  - A load samples hold occupancy as it was at the start of the cycle.
  - If hold is empty, IDLE_BYTE is used and a write in the same cycle is accepted into hold for the next byte.
  - cs_rise takes priority over sclk edges in the same cycle.
- A write is accepted in any state, including while deselected.

Optional Feature:
- Macro: SPI_SLAVE_TX_RX_EN.
- When defined:
  - Adds outputs rx_data[7:0] and rx_valid.
  - mosi is sampled on each sclk_rise into an LSB-first shift register: rx <= {mosi, rx[7:1]}.
  - rx_data updates and rx_valid pulses for one cycle, coincident with tx_done.
  - Abort discards the partial rx byte.
  - rx_data resets to 0.
- When undefined:
  - The rx ports are absent and mosi is unused.

Test Plan:
- Reset, write 0xA5, cs low, 8 mode-0 sclk cycles -> miso per rising edge is 1,0,1,0,0,1,0,1; one tx_done pulse; tx_ready high one cycle after load; miso_oe low after cs high.
- No write, cs low, 8 sclks -> miso shifts out 0xFF; one underrun pulse at load; tx_done pulses.
- Write 0x3C; during the first byte write 0xC3; 16 sclks with cs held low -> 0x3C then 0xC3 with no gap; two tx_done pulses; no underrun.
- Write 0x12, cs low, 3 sclks, cs high -> aborted pulse, miso_oe=0. Then write 0x81 and run a new frame -> 0x81 sent from bit0, no underrun.
- Assert rst mid-byte with clk stopped -> all outputs take their reset values immediately. Release rst, run a frame -> IDLE_BYTE and underrun pulse.
- With SPI_SLAVE_TX_RX_EN defined: master sends 0x5A while the block sends 0x96 -> rx_data=0x5A and rx_valid in the same cycle as tx_done; miso carries 0x96.

Source files
------------

// File: rtl/spi_slave_tx.sv
// spi_slave_tx: SPI mode-0 responder transmitter (CPOL=0, CPHA=0), LSB first,
// 8-bit frames, fed from a one-entry holding register with valid/ready.
// cs, sclk and mosi are oversampled on clk through SYNC_STAGES flops.
// Optional receive path: define SPI_SLAVE_TX_RX_EN to add rx_data/rx_valid.
`timescale 1ns/1ps
module spi_slave_tx #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       cs,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       tx_done,
  output logic       underrun,
  output logic       aborted
`ifdef SPI_SLAVE_TX_RX_EN
  ,
  output logic [7:0] rx_data,
  output logic       rx_valid
`endif
);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] cs_sync_p0, sclk_sync_p0;
  logic                   cs_prev_p1, sclk_prev_p1;
  logic                   cs_s, sclk_s;
  logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;

  logic       hold_full;
  logic [7:0] hold_data;
  logic [7:0] shreg;
  logic [7:0] load_byte;
  logic [2:0] bit_cnt;
  logic       reload;
  logic       wr_acc;

  logic       load_en, shift_en, rise_en, stop_en, last_bit;

  // Synchronizers and previous-value flops for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_p0   <= '1;
      sclk_sync_p0 <= '0;
      cs_prev_p1   <= 1'b1;
      sclk_prev_p1 <= 1'b0;
    end else begin
      cs_sync_p0[0]   <= cs;
      sclk_sync_p0[0] <= sclk;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync_p0[i]   <= cs_sync_p0[i-1];
        sclk_sync_p0[i] <= sclk_sync_p0[i-1];
      end
      cs_prev_p1   <= cs_s;
      sclk_prev_p1 <= sclk_s;
    end
  end

  assign cs_s      = cs_sync_p0[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_p0[SYNC_STAGES-1];
  assign cs_fall   = cs_prev_p1 & ~cs_s;
  assign cs_rise   = ~cs_prev_p1 & cs_s;
  assign sclk_rise = ~sclk_prev_p1 & sclk_s;
  assign sclk_fall = sclk_prev_p1 & ~sclk_s;

  // Hold occupancy is sampled at the start of the cycle, so a write landing
  // on an empty-hold load goes into hold while IDLE_BYTE is shifted out.
  assign tx_ready  = ~hold_full;
  assign wr_acc    = tx_valid & ~hold_full;
  assign load_byte = hold_full ? hold_data : IDLE_BYTE;
  assign last_bit  = rise_en & (bit_cnt == 3'd7);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: select on cs fall, deselect on cs rise
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/strobe decode; cs_rise wins over any sclk edge in the same cycle
  always_comb begin
    load_en  = 1'b0;
    shift_en = 1'b0;
    rise_en  = 1'b0;
    stop_en  = 1'b0;
    case (state)
      IDLE: load_en = cs_fall;
      SHIFT: begin
        if (cs_rise) begin
          stop_en = 1'b1;
        end else begin
          rise_en = sclk_rise;
          if (sclk_fall) begin
            if (reload) load_en  = 1'b1;
            else        shift_en = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Control registers: hold flag, bit counter, miso drive and event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      bit_cnt   <= 3'd0;
      reload    <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      tx_done   <= 1'b0;
      underrun  <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      tx_done  <= last_bit;
      underrun <= load_en & ~hold_full;
      aborted  <= stop_en & (bit_cnt != 3'd0);
      if (load_en && hold_full) hold_full <= 1'b0;
      else if (wr_acc)          hold_full <= 1'b1;
      if (stop_en) begin
        bit_cnt <= 3'd0;
        reload  <= 1'b0;
        miso_oe <= 1'b0;
        miso    <= 1'b0;
      end else begin
        if (rise_en) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (last_bit) reload <= 1'b1;
        end
        if (load_en) begin
          reload  <= 1'b0;
          miso_oe <= 1'b1;
          miso    <= load_byte[0];
        end else if (shift_en) begin
          miso <= shreg[1];
        end
      end
    end
  end

  // Datapath registers: holding byte and transmit shift register
  always_ff @(posedge clk) begin
    if (wr_acc) hold_data <= tx_data;
    if (load_en)       shreg <= load_byte;
    else if (shift_en) shreg <= {1'b0, shreg[7:1]};
  end

`ifdef SPI_SLAVE_TX_RX_EN
  logic [SYNC_STAGES-1:0] mosi_dly_p0;
  logic                   mosi_s;
  logic [7:0]             rx_sh;

  assign mosi_s = mosi_dly_p0[SYNC_STAGES-1];

  // mosi delayed by the same depth as sclk so it lines up with sclk_rise
  always_ff @(posedge clk) begin
    mosi_dly_p0[0] <= mosi;
    for (int i = 1; i < SYNC_STAGES; i++) mosi_dly_p0[i] <= mosi_dly_p0[i-1];
    if (rise_en) rx_sh <= {mosi_s, rx_sh[7:1]};
  end

  // Received byte presented together with tx_done; partial bytes never surface
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= last_bit;
      if (last_bit) rx_data <= {mosi_s, rx_sh[7:1]};
    end
  end
`else
  logic unused_mosi;
  assign unused_mosi = mosi;
`endif

endmodule
